// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the UART word receiver.
// Optional build macro: UART_RX_MAJORITY_EN (2-of-3 bit sampling in uart_rx_char).
package uart_rx_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } rx_state_t;

    localparam int unsigned PARITY_NONE = 0;
    localparam int unsigned PARITY_EVEN = 1;
    localparam int unsigned PARITY_ODD  = 2;

    // Narrow characters are zero-extended, which leaves the XOR unchanged.
    function automatic logic parity_ok(input logic [7:0] data, input logic par_bit,
                                       input int unsigned mode);
        logic p;
        p = (^data) ^ par_bit;
        case (mode)
            PARITY_EVEN: parity_ok = !p;
            PARITY_ODD:  parity_ok = p;
            default:     parity_ok = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/uart_rx_char.sv
// Single-character UART receiver: rx synchroniser, bit FSM, parity and stop checking.
// Macro UART_RX_MAJORITY_EN: data/parity/stop bits use a 2-of-3 vote decided at mid+1.
module uart_rx_char
    import uart_rx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 14,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY_MODE  = 1,
    parameter bit          MSB_FIRST    = 1'b1,
    parameter logic [7:0]  ERR_FILL     = 8'h3F
) (
    input  logic                 clk_3125,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] char_data,
    output logic                 char_par_err,
    output logic                 char_frm_err,
    output logic                 char_done,
    output logic                 idle
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam int unsigned BIT_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] HALF = CNT_W'(CLKS_PER_BIT / 2);
`ifdef UART_RX_MAJORITY_EN
    localparam int unsigned HIST_W = 2;
    localparam logic [CNT_W-1:0] SAMPLE_AT = CNT_W'(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] RESTART   = CNT_W'(1);
`else
    localparam int unsigned HIST_W = 1;
    localparam logic [CNT_W-1:0] SAMPLE_AT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] RESTART   = '0;
`endif

    rx_state_t            state_q, state_d;
    logic                 rx_meta_q, rx_s_q;
    logic [HIST_W-1:0]    hist_q;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 par_err_q, par_err_d;
    logic                 stop_wait_q, stop_wait_d;
    logic                 sample_bit;
    logic                 at_sample;

`ifdef UART_RX_MAJORITY_EN
    // hist_q[0] is rx_s at mid, hist_q[1] at mid-1 when cnt_q reaches SAMPLE_AT.
    assign sample_bit = (rx_s_q & hist_q[0]) | (rx_s_q & hist_q[1]) | (hist_q[0] & hist_q[1]);
`else
    assign sample_bit = rx_s_q;
`endif
    assign at_sample = (cnt_q == SAMPLE_AT);
    assign idle      = (state_q == StIdle);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_d        = bit_q;
        data_d       = data_q;
        par_err_d    = par_err_q;
        stop_wait_d  = stop_wait_q;
        char_done    = 1'b0;
        char_frm_err = 1'b0;
        char_par_err = par_err_q;
        char_data    = data_q;
        case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (!rx_s_q && hist_q[0]) state_d = StStart;
            end
            StStart: begin
                if (cnt_q == HALF) begin
                    cnt_d     = '0;
                    bit_d     = '0;
                    par_err_d = 1'b0;
                    state_d   = rx_s_q ? StIdle : StData;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StData: begin
                if (at_sample) begin
                    cnt_d = RESTART;
                    if (MSB_FIRST) data_d = {data_q[DATA_BITS-2:0], sample_bit};
                    else           data_d = {sample_bit, data_q[DATA_BITS-1:1]};
                    if (bit_q == BIT_W'(DATA_BITS - 1)) begin
                        state_d = (PARITY_MODE == PARITY_NONE) ? StStop : StParity;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StParity: begin
                if (at_sample) begin
                    cnt_d     = RESTART;
                    par_err_d = !parity_ok(8'(data_q), sample_bit, PARITY_MODE);
                    state_d   = StStop;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StStop: begin
                if (stop_wait_q) begin
                    // Hold off after a break so the low line cannot look like a new start bit.
                    if (rx_s_q) begin
                        stop_wait_d = 1'b0;
                        state_d     = StIdle;
                    end
                end else if (at_sample) begin
                    char_done    = 1'b1;
                    char_frm_err = !sample_bit;
                    if (par_err_q || !sample_bit) char_data = ERR_FILL[DATA_BITS-1:0];
                    if (sample_bit) state_d = StIdle;
                    else            stop_wait_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_3125 or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
            hist_q      <= '1;
            state_q     <= StIdle;
            cnt_q       <= '0;
            bit_q       <= '0;
            data_q      <= '0;
            par_err_q   <= 1'b0;
            stop_wait_q <= 1'b0;
        end else begin
            rx_meta_q   <= rx;
            rx_s_q      <= rx_meta_q;
            hist_q      <= HIST_W'({hist_q, rx_s_q});
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            data_q      <= data_d;
            par_err_q   <= par_err_d;
            stop_wait_q <= stop_wait_d;
        end
    end

endmodule

// File: rtl/uart_word_receiver.sv
// Packs UART characters into WORD_BYTES-wide words with valid/ready, overrun and timeout.
// Macro UART_RX_MAJORITY_EN: forwarded to uart_rx_char for 2-of-3 bit sampling.
module uart_word_receiver
    import uart_rx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 14,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned WORD_BYTES   = 2,
    parameter int unsigned PARITY_MODE  = 1,
    parameter bit          MSB_FIRST    = 1'b1,
    parameter logic [7:0]  ERR_FILL     = 8'h3F,
    parameter int unsigned TIMEOUT_BITS = 32
) (
    input  logic                    clk_3125,
    input  logic                    rst_n,
    input  logic                    rx,
    output logic [8*WORD_BYTES-1:0] rx_msg,
    output logic                    rx_valid,
    input  logic                    rx_ready,
    output logic                    rx_err_par,
    output logic                    rx_err_frm,
    output logic                    rx_overrun,
    output logic                    rx_timeout
);

    localparam int unsigned IDX_W   = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam int unsigned TMO_CYC = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int unsigned TMO_W   = $clog2(TMO_CYC);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_BYTES - 1);

    logic [DATA_BITS-1:0]    char_data;
    logic                    char_par_err, char_frm_err, char_done, char_idle;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [8*WORD_BYTES-1:0] asm_q, asm_d, merged;
    logic                    asm_par_q, asm_par_d, asm_frm_q, asm_frm_d;
    logic [8*WORD_BYTES-1:0] msg_q, msg_d;
    logic                    valid_q, valid_d;
    logic                    err_par_q, err_par_d, err_frm_q, err_frm_d;
    logic                    ovr_q, ovr_d, tmo_q, tmo_d;
    logic [TMO_W-1:0]        tmo_cnt_q, tmo_cnt_d;

    uart_rx_char #(
        .CLKS_PER_BIT(CLKS_PER_BIT),
        .DATA_BITS   (DATA_BITS),
        .PARITY_MODE (PARITY_MODE),
        .MSB_FIRST   (MSB_FIRST),
        .ERR_FILL    (ERR_FILL)
    ) u_char (
        .clk_3125    (clk_3125),
        .rst_n       (rst_n),
        .rx          (rx),
        .char_data   (char_data),
        .char_par_err(char_par_err),
        .char_frm_err(char_frm_err),
        .char_done   (char_done),
        .idle        (char_idle)
    );

    // Slot 0 is the most significant byte.
    always_comb begin
        merged = asm_q;
        merged[8*(WORD_BYTES-1-int'(idx_q)) +: 8] = 8'(char_data);
    end

    always_comb begin
        idx_d     = idx_q;
        asm_d     = asm_q;
        asm_par_d = asm_par_q;
        asm_frm_d = asm_frm_q;
        msg_d     = msg_q;
        valid_d   = valid_q;
        err_par_d = err_par_q;
        err_frm_d = err_frm_q;
        ovr_d     = 1'b0;
        tmo_d     = 1'b0;
        tmo_cnt_d = '0;
        if (valid_q && rx_ready) valid_d = 1'b0;
        if (char_done) begin
            if (idx_q == LAST_IDX) begin
                idx_d     = '0;
                asm_par_d = 1'b0;
                asm_frm_d = 1'b0;
                if (valid_q && !rx_ready) begin
                    ovr_d = 1'b1;
                end else begin
                    msg_d     = merged;
                    valid_d   = 1'b1;
                    err_par_d = asm_par_q | char_par_err;
                    err_frm_d = asm_frm_q | char_frm_err;
                end
            end else begin
                idx_d     = idx_q + 1'b1;
                asm_d     = merged;
                asm_par_d = asm_par_q | char_par_err;
                asm_frm_d = asm_frm_q | char_frm_err;
            end
        end
        if (char_idle && idx_q != '0) begin
            if (tmo_cnt_q == TMO_W'(TMO_CYC - 1)) begin
                tmo_d     = 1'b1;
                idx_d     = '0;
                asm_par_d = 1'b0;
                asm_frm_d = 1'b0;
            end else begin
                tmo_cnt_d = tmo_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_3125 or negedge rst_n) begin
        if (!rst_n) begin
            idx_q     <= '0;
            asm_q     <= '0;
            asm_par_q <= 1'b0;
            asm_frm_q <= 1'b0;
            msg_q     <= '0;
            valid_q   <= 1'b0;
            err_par_q <= 1'b0;
            err_frm_q <= 1'b0;
            ovr_q     <= 1'b0;
            tmo_q     <= 1'b0;
            tmo_cnt_q <= '0;
        end else begin
            idx_q     <= idx_d;
            asm_q     <= asm_d;
            asm_par_q <= asm_par_d;
            asm_frm_q <= asm_frm_d;
            msg_q     <= msg_d;
            valid_q   <= valid_d;
            err_par_q <= err_par_d;
            err_frm_q <= err_frm_d;
            ovr_q     <= ovr_d;
            tmo_q     <= tmo_d;
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

    assign rx_msg     = msg_q;
    assign rx_valid   = valid_q;
    assign rx_err_par = err_par_q;
    assign rx_err_frm = err_frm_q;
    assign rx_overrun = ovr_q;
    assign rx_timeout = tmo_q;

endmodule

// File: tb/tb_uart_word_receiver.sv
// Self-checking bench for uart_word_receiver at default parameters (8E1, MSB first, 2 bytes).
module tb_uart_word_receiver;

    localparam int C = 14;

    logic        clk_3125 = 1'b0;
    logic        rst_n;
    logic        rx;
    logic        rx_ready;
    logic [15:0] rx_msg;
    logic        rx_valid, rx_err_par, rx_err_frm, rx_overrun, rx_timeout;

    uart_word_receiver dut (
        .clk_3125  (clk_3125),
        .rst_n     (rst_n),
        .rx        (rx),
        .rx_msg    (rx_msg),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .rx_err_par(rx_err_par),
        .rx_err_frm(rx_err_frm),
        .rx_overrun(rx_overrun),
        .rx_timeout(rx_timeout)
    );

    always #5 clk_3125 = ~clk_3125;

    typedef struct {
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic        flip0;
        logic        stop0;
        logic [15:0] exp_msg;
        logic        exp_par;
        logic        exp_frm;
    } vec_t;

    logic [17:0] exp_q[$];
    int n_pass = 0;
    int n_total = 0;
    int ovr_cnt = 0;
    int tmo_cnt = 0;
    int valid_cycles = 0;
    int accepts = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h", name, got, exp);
    endtask

    task automatic bit_time(input int n);
        repeat (n * C) @(negedge clk_3125);
    endtask

    // Even parity frame, MSB first; a low stop bit is followed by break_bits of low line.
    task automatic send_char(input logic [7:0] b, input logic flip, input logic stop_bit,
                             input int break_bits);
        rx = 1'b0;
        bit_time(1);
        for (int i = 7; i >= 0; i--) begin
            rx = b[i];
            bit_time(1);
        end
        rx = (^b) ^ flip;
        bit_time(1);
        rx = stop_bit;
        bit_time(1);
        if (!stop_bit) bit_time(break_bits);
        rx = 1'b1;
        bit_time(2);
    endtask

    task automatic set_ready(input logic r);
        @(posedge clk_3125);
        #2 rx_ready = r;
    endtask

    // Scoreboard: every accepted word is matched against the oldest expectation.
    always @(negedge clk_3125) begin
        if (rst_n) begin
            if (rx_overrun) ovr_cnt++;
            if (rx_timeout) tmo_cnt++;
            if (rx_valid) valid_cycles++;
            if (rx_valid && rx_ready) begin
                accepts++;
                if (exp_q.size() == 0) begin
                    check("unexpected_word", {46'd0, rx_msg, rx_err_par, rx_err_frm}, 64'd0);
                end else begin
                    logic [17:0] e;
                    e = exp_q.pop_front();
                    check("word_msg", 64'(rx_msg), 64'(e[17:2]));
                    check("word_err_par", 64'(rx_err_par), 64'(e[1]));
                    check("word_err_frm", 64'(rx_err_frm), 64'(e[0]));
                end
            end
        end
    end

    vec_t vecs[5];

    initial begin
        vecs[0] = '{8'hA5, 8'h3C, 1'b0, 1'b1, 16'hA53C, 1'b0, 1'b0};
        vecs[1] = '{8'h81, 8'h00, 1'b1, 1'b1, 16'h3F00, 1'b1, 1'b0};
        vecs[2] = '{8'h55, 8'h11, 1'b0, 1'b0, 16'h3F11, 1'b0, 1'b1};
        vecs[3] = '{8'h01, 8'h80, 1'b0, 1'b1, 16'h0180, 1'b0, 1'b0};
        vecs[4] = '{8'hFF, 8'h7E, 1'b0, 1'b1, 16'hFF7E, 1'b0, 1'b0};

        rst_n    = 1'b0;
        rx       = 1'b1;
        rx_ready = 1'b1;
        repeat (3) @(negedge clk_3125);
        check("reset_outputs",
              {42'd0, rx_msg, rx_valid, rx_err_par, rx_err_frm, rx_overrun, rx_timeout}, 64'd0);
        rst_n = 1'b1;
        bit_time(2);

        for (int i = 0; i < 5; i++) begin
            exp_q.push_back({vecs[i].exp_msg, vecs[i].exp_par, vecs[i].exp_frm});
            send_char(vecs[i].b0, vecs[i].flip0, vecs[i].stop0, 3);
            send_char(vecs[i].b1, 1'b0, 1'b1, 0);
        end
        check("table_drained", 64'(exp_q.size()), 64'd0);
        check("valid_one_cycle", 64'(valid_cycles), 64'(accepts));
        check("table_accepts", 64'(accepts), 64'd5);

        // Overrun: second word dropped while the first is held.
        set_ready(1'b0);
        exp_q.push_back({16'h1234, 2'b00});
        send_char(8'h12, 1'b0, 1'b1, 0);
        send_char(8'h34, 1'b0, 1'b1, 0);
        send_char(8'h56, 1'b0, 1'b1, 0);
        send_char(8'h78, 1'b0, 1'b1, 0);
        check("ovr_held_msg", 64'(rx_msg), 64'h1234);
        check("ovr_held_valid", 64'(rx_valid), 64'd1);
        check("ovr_pulses", 64'(ovr_cnt), 64'd1);
        set_ready(1'b1);
        repeat (4) @(negedge clk_3125);
        check("ovr_accept_valid", 64'(rx_valid), 64'd0);
        check("ovr_drained", 64'(exp_q.size()), 64'd0);

        // Timeout discards the lone 0xAB and realigns on 0xCD.
        send_char(8'hAB, 1'b0, 1'b1, 0);
        bit_time(40);
        check("tmo_pulses", 64'(tmo_cnt), 64'd1);
        exp_q.push_back({16'hCDEF, 2'b00});
        send_char(8'hCD, 1'b0, 1'b1, 0);
        send_char(8'hEF, 1'b0, 1'b1, 0);
        check("tmo_drained", 64'(exp_q.size()), 64'd0);

        // Short low glitch must not register as a character.
        rx = 1'b0;
        repeat (3) @(negedge clk_3125);
        rx = 1'b1;
        bit_time(2);
        exp_q.push_back({16'h1357, 2'b00});
        send_char(8'h13, 1'b0, 1'b1, 0);
        send_char(8'h57, 1'b0, 1'b1, 0);
        check("glitch_drained", 64'(exp_q.size()), 64'd0);

        // Async reset mid-DATA with a word held on the outputs.
        set_ready(1'b0);
        send_char(8'h24, 1'b0, 1'b1, 0);
        send_char(8'h68, 1'b0, 1'b1, 0);
        check("pre_rst_msg", 64'(rx_msg), 64'h2468);
        check("pre_rst_valid", 64'(rx_valid), 64'd1);
        send_char(8'h99, 1'b0, 1'b1, 0);
        rx = 1'b0;
        bit_time(1);
        for (int i = 0; i < 4; i++) begin
            rx = i[0];
            bit_time(1);
        end
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_outputs",
              {42'd0, rx_msg, rx_valid, rx_err_par, rx_err_frm, rx_overrun, rx_timeout}, 64'd0);
        rx = 1'b1;
        repeat (3) @(negedge clk_3125);
        rst_n    = 1'b1;
        rx_ready = 1'b1;
        bit_time(2);
        exp_q.push_back({16'hBEEF, 2'b00});
        send_char(8'hBE, 1'b0, 1'b1, 0);
        send_char(8'hEF, 1'b0, 1'b1, 0);
        bit_time(2);
        check("final_drained", 64'(exp_q.size()), 64'd0);
        check("final_ovr", 64'(ovr_cnt), 64'd1);
        check("final_tmo", 64'(tmo_cnt), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
